// File: rtl/step_move_if.sv
// step_move_if: bundles the signals of the step-move sequencer. These are the
// requester handshake and the pulse-generator / motor-select side.
//   master : requesters + generator side (drives req/req_num/req_dir/pg_sign)
//   slave  : the sequencer (drives ack/done/err/pg_*/motor_sel/dir/busy)
// Channel i's pulse count sits at req_num[i*CNT_W +: CNT_W].
interface step_move_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 10
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] req_num;
    logic [N_REQ-1:0]       req_dir;
    logic [N_REQ-1:0]       ack;
    logic [N_REQ-1:0]       done;
    logic [N_REQ-1:0]       err;
    logic                   pg_enable;
    logic [CNT_W-1:0]       pg_pulse_num;
    logic                   pg_sign;
    logic [N_REQ-1:0]       motor_sel;
    logic                   dir;
    logic                   busy;

    modport master (
        output req, req_num, req_dir, pg_sign,
        input  ack, done, err, pg_enable, pg_pulse_num, motor_sel, dir, busy
    );

    modport slave (
        input  req, req_num, req_dir, pg_sign,
        output ack, done, err, pg_enable, pg_pulse_num, motor_sel, dir, busy
    );
endinterface

// File: rtl/step_move_sequencer.sv
// step_move_sequencer: round-robin scheduler of per-channel move requests onto
// one shared step-pulse generator. It runs IDLE -> SETUP (direction setup) ->
// RUN (count falling pg_sign edges) -> SETTLE (generator held off) -> FINISH.
// A zero pulse count goes from IDLE straight to FINISH.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   bus (slave)  req/req_num/req_dir/pg_sign in; ack/done/err (one-cycle
//                pulses), pg_enable, pg_pulse_num, motor_sel, dir, busy out
// Optional feature: define STEP_TIMEOUT_EN to abort a move when RUN sees no
// pg_sign edge for TIMEOUT cycles. The abort is reported on err instead of done.
// Without the macro err is constant 0 and RUN waits indefinitely.
module step_move_sequencer #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned DIR_SETUP = 8,
    parameter int unsigned SETTLE    = 16,
    parameter int unsigned TIMEOUT   = 4095
) (
    input  logic       clk,
    input  logic       rst,
    step_move_if.slave bus
);

    localparam int unsigned GW      = $clog2(N_REQ);
    localparam int unsigned PH_MAX  = (DIR_SETUP > SETTLE) ? DIR_SETUP : SETTLE;
    localparam int unsigned TMR_MAX = (TIMEOUT > PH_MAX) ? TIMEOUT : PH_MAX;
    localparam int unsigned TW      = $clog2(TMR_MAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]       r_state,   w_state_n;
    logic [GW-1:0]    r_last,    w_last_n;
    logic [GW-1:0]    r_gnt,     w_gnt_n;
    logic [TW-1:0]    r_tmr,     w_tmr_n;
    logic [CNT_W-1:0] r_pcnt,    w_pcnt_n;
    logic [CNT_W-1:0] r_num,     w_num_n;
    logic             r_dir,     w_dir_n;
    logic             r_en,      w_en_n;
    logic             r_busy,    w_busy_n;
    logic             r_sign_q,  w_sign_n;
    logic [N_REQ-1:0] r_ack,     w_ack_n;
    logic [N_REQ-1:0] r_done,    w_done_n;
    logic [N_REQ-1:0] r_sel,     w_sel_n;
    logic             w_found;
    logic [GW-1:0]    w_pick;
    logic [CNT_W-1:0] w_pick_num;
    logic             w_pick_dir;
    logic             w_fall;
`ifdef STEP_TIMEOUT_EN
    logic             r_abort,   w_abort_n;
    logic [N_REQ-1:0] r_err,     w_err_n;
    logic             w_edge;
`endif

    // Round-robin pick: the first requester at or after last_grant+1.
    // Walking downward lets the nearest candidate overwrite farther ones.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            if (bus.req[GW'((int'(r_last) + k) % int'(N_REQ))]) begin
                w_found = 1'b1;
                w_pick  = GW'((int'(r_last) + k) % int'(N_REQ));
            end
        end
    end

    // Count and direction of the picked channel.
    always_comb begin
        w_pick_num = '0;
        w_pick_dir = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_pick == GW'(i)) begin
                w_pick_num = bus.req_num[i*CNT_W +: CNT_W];
                w_pick_dir = bus.req_dir[i];
            end
        end
    end

    // r_sign_q is held at 0 outside RUN, so the edge detector restarts on RUN entry.
    assign w_fall = r_sign_q & ~bus.pg_sign;
`ifdef STEP_TIMEOUT_EN
    assign w_edge = r_sign_q ^ bus.pg_sign;
`endif

    // Next-state and next-output logic. One timer serves the setup and settle
    // phases and the inter-edge watchdog.
    always_comb begin
        w_state_n = r_state;
        w_last_n  = r_last;
        w_gnt_n   = r_gnt;
        w_tmr_n   = r_tmr;
        w_pcnt_n  = r_pcnt;
        w_num_n   = r_num;
        w_dir_n   = r_dir;
        w_en_n    = r_en;
        w_sel_n   = r_sel;
        w_ack_n   = '0;
        w_done_n  = '0;
        w_sign_n  = 1'b0;
`ifdef STEP_TIMEOUT_EN
        w_abort_n = r_abort;
        w_err_n   = '0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_n   = w_pick;
                    w_num_n   = w_pick_num;
                    w_dir_n   = w_pick_dir;
                    w_sel_n   = N_REQ'(1) << w_pick;
                    w_ack_n   = N_REQ'(1) << w_pick;
                    w_pcnt_n  = '0;
                    w_tmr_n   = '0;
`ifdef STEP_TIMEOUT_EN
                    w_abort_n = 1'b0;
`endif
                    w_state_n = (w_pick_num == '0) ? S_FINISH : S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_tmr == TW'(DIR_SETUP - 1)) begin
                    w_tmr_n   = '0;
                    w_en_n    = 1'b1;
                    w_state_n = S_RUN;
                end else begin
                    w_tmr_n = TW'(r_tmr + 1'b1);
                end
            end
            S_RUN: begin
                w_sign_n = bus.pg_sign;
                if (w_fall) begin
                    w_pcnt_n = CNT_W'(r_pcnt + 1'b1);
                end
`ifdef STEP_TIMEOUT_EN
                w_tmr_n = w_edge ? '0 : TW'(r_tmr + 1'b1);
`endif
                if (w_fall && (CNT_W'(r_pcnt + 1'b1) == r_num)) begin
                    w_en_n    = 1'b0;
                    w_tmr_n   = '0;
                    w_state_n = S_SETTLE;
`ifdef STEP_TIMEOUT_EN
                end else if (!w_edge && (r_tmr == TW'(TIMEOUT - 1))) begin
                    w_en_n    = 1'b0;
                    w_tmr_n   = '0;
                    w_abort_n = 1'b1;
                    w_state_n = S_SETTLE;
`endif
                end
            end
            S_SETTLE: begin
                if (r_tmr == TW'(SETTLE - 1)) begin
                    // Completion is registered here so it shows in the FINISH cycle.
                    w_tmr_n   = '0;
                    w_state_n = S_FINISH;
`ifdef STEP_TIMEOUT_EN
                    if (r_abort) w_err_n  = N_REQ'(1) << r_gnt;
                    else         w_done_n = N_REQ'(1) << r_gnt;
`else
                    w_done_n  = N_REQ'(1) << r_gnt;
`endif
                end else begin
                    w_tmr_n = TW'(r_tmr + 1'b1);
                end
            end
            S_FINISH: begin
                // Zero-count moves arrive straight from IDLE, so done is issued here.
                if (r_num == '0) begin
                    w_done_n = N_REQ'(1) << r_gnt;
                end
                w_sel_n   = '0;
                w_last_n  = r_gnt;
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
`ifdef STEP_TIMEOUT_EN
        w_busy_n = (w_state_n != S_IDLE) || (|w_done_n) || (|w_err_n);
`else
        w_busy_n = (w_state_n != S_IDLE) || (|w_done_n);
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_last   <= GW'(N_REQ - 1);
            r_gnt    <= '0;
            r_tmr    <= '0;
            r_pcnt   <= '0;
            r_num    <= '0;
            r_dir    <= 1'b0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_sign_q <= 1'b0;
            r_ack    <= '0;
            r_done   <= '0;
            r_sel    <= '0;
`ifdef STEP_TIMEOUT_EN
            r_abort  <= 1'b0;
            r_err    <= '0;
`endif
        end else begin
            r_state  <= w_state_n;
            r_last   <= w_last_n;
            r_gnt    <= w_gnt_n;
            r_tmr    <= w_tmr_n;
            r_pcnt   <= w_pcnt_n;
            r_num    <= w_num_n;
            r_dir    <= w_dir_n;
            r_en     <= w_en_n;
            r_busy   <= w_busy_n;
            r_sign_q <= w_sign_n;
            r_ack    <= w_ack_n;
            r_done   <= w_done_n;
            r_sel    <= w_sel_n;
`ifdef STEP_TIMEOUT_EN
            r_abort  <= w_abort_n;
            r_err    <= w_err_n;
`endif
        end
    end

    assign bus.ack          = r_ack;
    assign bus.done         = r_done;
    assign bus.pg_enable    = r_en;
    assign bus.pg_pulse_num = r_num;
    assign bus.motor_sel    = r_sel;
    assign bus.dir          = r_dir;
    assign bus.busy         = r_busy;
`ifdef STEP_TIMEOUT_EN
    assign bus.err          = r_err;
`else
    assign bus.err          = '0;
`endif

endmodule

// File: tb/tb_step_move_sequencer.sv
// tb_step_move_sequencer: directed bench for step_move_sequencer. A free-running
// generator model emits a pulse every 4 cycles while pg_enable is high. The
// sequencer must therefore stop it after exactly the latched count.
module tb_step_move_sequencer;
    localparam int unsigned N_REQ     = 4;
    localparam int unsigned CNT_W     = 10;
    localparam int unsigned DIR_SETUP = 8;
    localparam int unsigned SETTLE    = 16;
    localparam int unsigned TIMEOUT   = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    step_move_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) bus ();

    step_move_sequencer #(
        .N_REQ(N_REQ), .CNT_W(CNT_W), .DIR_SETUP(DIR_SETUP),
        .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Generator model: rising at phase 1, falling at phase 3.
    int gen_ph = 0;
    int gen_falls = 0;
    int gen_last_fall = -1;
    bit gen_stall = 1'b0;
    initial begin
        bus.pg_sign = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.pg_enable && !gen_stall) begin
                gen_ph = (gen_ph + 1) % 4;
                if (gen_ph == 1) bus.pg_sign = 1'b1;
                else if (gen_ph == 3) begin
                    bus.pg_sign = 1'b0;
                    gen_falls++;
                    gen_last_fall = cyc;
                end
            end else begin
                gen_ph = 0;
                bus.pg_sign = 1'b0;
            end
        end
    end

    // Output monitor: grant order, pulse counts and invariant violations.
    int ack_cnt[N_REQ] = '{default: 0};
    int done_cnt[N_REQ] = '{default: 0};
    int err_cnt = 0;
    int viol = 0;
    int en_rises = 0;
    bit en_q = 1'b0;
    int order[$];
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (bus.ack[i]) begin ack_cnt[i]++; order.push_back(i); end
                if (bus.done[i]) done_cnt[i]++;
                if (bus.err[i]) err_cnt++;
                if (int'(bus.ack[i]) + int'(bus.done[i]) + int'(bus.err[i]) > 1) viol++;
            end
            if (!$onehot0(bus.motor_sel)) viol++;
            if (bus.pg_enable && (bus.motor_sel == '0)) viol++;
            if (bus.pg_enable && !en_q) en_rises++;
            en_q = bus.pg_enable;
        end
    end

    // kind: 0 ack[ch], 1 done[ch], 2 err[ch], 3 enable high, 4 enable low.
    // Returns the cycle of the event, or -1 when the limit expires.
    task automatic wait_sig(input int kind, input int ch, input int limit, output int at);
        bit hit;
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            case (kind)
                0:       hit = bus.ack[ch];
                1:       hit = bus.done[ch];
                2:       hit = bus.err[ch];
                3:       hit = bus.pg_enable;
                default: hit = !bus.pg_enable;
            endcase
            if (hit) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic set_req(input int ch, input int num, input bit d);
        bus.req_num[ch*CNT_W +: CNT_W] = CNT_W'(num);
        bus.req_dir[ch] = d;
        bus.req[ch] = 1'b1;
    endtask

    initial begin
        int t, at, r, f, f0, n0, rise0;
        bus.req = '0;
        bus.req_num = '0;
        bus.req_dir = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_en", bus.pg_enable, 0);
        chk("rst_sel", bus.motor_sel, 0);
        chk("rst_pnum", bus.pg_pulse_num, 0);
        rst = 1'b1;
        @(negedge clk);

        // Round-robin: all four channels at once, count 2 each.
        for (int k = 0; k < 4; k++) set_req(k, 2, k[0]);
        for (int k = 0; k < 4; k++) begin
            wait_sig(0, k, 100, at);
            chk("rr_ack_seen", (at < 0) ? 0 : 1, 1);
            bus.req[k] = 1'b0;
            chk("rr_sel", bus.motor_sel, 1 << k);
            chk("rr_dir", bus.dir, k % 2);
            wait_sig(1, k, 200, at);
            chk("rr_done_seen", (at < 0) ? 0 : 1, 1);
        end
        chk("rr_order_len", order.size(), 4);
        for (int k = 0; k < 4; k++) chk("rr_order", (order.size() > k) ? order[k] : -1, k);

        // Single move of 5 pulses; request values change after ack.
        @(negedge clk);
        f0 = gen_falls;
        set_req(0, 5, 1'b1);
        t = cyc;
        wait_sig(0, 0, 20, at);
        chk("single_ack_lat", at, t + 1);
        bus.req[0] = 1'b0;
        bus.req_num[0 +: CNT_W] = CNT_W'(9);
        bus.req_dir[0] = 1'b0;
        chk("single_sel", bus.motor_sel, 1);
        chk("single_dir", bus.dir, 1);
        chk("single_busy", bus.busy, 1);
        chk("single_en_low", bus.pg_enable, 0);
        wait_sig(3, 0, 40, r);
        chk("single_en_rise", r, t + 1 + DIR_SETUP);
        chk("latch_num", bus.pg_pulse_num, 5);
        chk("latch_dir", bus.dir, 1);
        wait_sig(4, 0, 200, f);
        chk("latch_num_end", bus.pg_pulse_num, 5);
        chk("single_en_fall", f, gen_last_fall + 1);
        wait_sig(1, 0, 60, at);
        chk("single_done_lat", at, f + SETTLE);
        chk("single_pulses", gen_falls - f0, 5);
        chk("single_busy_done", bus.busy, 1);
        @(negedge clk);
        chk("single_busy_after", bus.busy, 0);
        chk("single_sel_after", bus.motor_sel, 0);

        // Zero count on channel 2.
        rise0 = en_rises;
        set_req(2, 0, 1'b0);
        t = cyc;
        wait_sig(0, 2, 20, at);
        chk("zero_ack_lat", at, t + 1);
        bus.req[2] = 1'b0;
        wait_sig(1, 2, 20, at);
        chk("zero_done_lat", at, t + 2);
        chk("zero_busy_done", bus.busy, 1);
        repeat (4) @(negedge clk);
        chk("zero_no_enable", en_rises - rise0, 0);

        // Reset in the middle of a 10-pulse move on channel 3.
        f0 = gen_falls;
        set_req(3, 10, 1'b1);
        wait_sig(0, 3, 20, at);
        bus.req[3] = 1'b0;
        wait_sig(3, 3, 40, at);
        for (int i = 0; i < 100 && (gen_falls - f0) < 3; i++) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_en", bus.pg_enable, 0);
        chk("midrst_sel", bus.motor_sel, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_dir", bus.dir, 0);
        chk("midrst_pnum", bus.pg_pulse_num, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        set_req(1, 1, 1'b0);
        t = cyc;
        wait_sig(0, 1, 20, at);
        chk("post_rst_ack", at, t + 1);
        chk("post_rst_grant", (order.size() > 0) ? order[$] : -1, 1);
        bus.req[1] = 1'b0;
        wait_sig(1, 1, 100, at);
        chk("post_rst_done_seen", (at < 0) ? 0 : 1, 1);

        // After another reset, channel 0 wins; a re-request right after done loses to channel 1.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n0 = order.size();
        set_req(0, 1, 1'b0);
        set_req(1, 1, 1'b1);
        wait_sig(0, 0, 20, at);
        bus.req[0] = 1'b0;
        wait_sig(1, 0, 100, at);
        bus.req[0] = 1'b1;
        wait_sig(0, 1, 20, at);
        bus.req[1] = 1'b0;
        wait_sig(1, 1, 100, at);
        wait_sig(0, 0, 20, at);
        bus.req[0] = 1'b0;
        wait_sig(1, 0, 100, at);
        chk("rereq_order0", (order.size() > n0) ? order[n0] : -1, 0);
        chk("rereq_order1", (order.size() > n0 + 1) ? order[n0+1] : -1, 1);
        chk("rereq_order2", (order.size() > n0 + 2) ? order[n0+2] : -1, 0);

`ifdef STEP_TIMEOUT_EN
        // Stalled generator: the move aborts with err after the watchdog and settle time.
        @(negedge clk);
        gen_stall = 1'b1;
        set_req(3, 4, 1'b0);
        wait_sig(0, 3, 20, at);
        bus.req[3] = 1'b0;
        wait_sig(3, 3, 40, r);
        wait_sig(4, 3, 300, f);
        chk("tmo_en_fall", f, r + TIMEOUT);
        wait_sig(2, 3, 60, at);
        chk("tmo_err_lat", at, f + SETTLE);
        gen_stall = 1'b0;
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("ack_cnt0", ack_cnt[0], 4);
        chk("ack_cnt1", ack_cnt[1], 3);
        chk("ack_cnt2", ack_cnt[2], 2);
`ifdef STEP_TIMEOUT_EN
        chk("ack_cnt3", ack_cnt[3], 3);
        chk("err_cnt", err_cnt, 1);
`else
        chk("ack_cnt3", ack_cnt[3], 2);
        chk("err_cnt", err_cnt, 0);
`endif
        chk("done_cnt0", done_cnt[0], 4);
        chk("done_cnt1", done_cnt[1], 3);
        chk("done_cnt2", done_cnt[2], 2);
        chk("done_cnt3", done_cnt[3], 1);
        chk("invariants", viol, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not complete (checks %0d errors %0d)", n_chk, n_err);
        $fatal(1);
    end

endmodule
